// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op encodings and FSM state type for the multiply/divide unit
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_div_step.sv
// rtl/md_div_step.sv - one restoring-division step, MSB of the dividend shifted in first
module md_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // quo_i carries the unconsumed dividend bits at the top and builds quotient bits at the bottom
    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, divisor_i});
    assign diff    = shifted[WIDTH-1:0] - divisor_i;

    always_comb begin
        rem_o = shifted[WIDTH-1:0];
        quo_o = {quo_i[WIDTH-2:0], 1'b0};
        if (fits) begin
            rem_o = diff;
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_res_q, neg_res_d;
    logic               divz_q, divz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               sgn_op;
    logic               neg_a_in;
    logic               neg_b_in;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;

    assign sgn_op   = (op_i == MD_MULT) || (op_i == MD_DIV);
    assign neg_a_in = sgn_op & a_i[WIDTH-1];
    assign neg_b_in = sgn_op & b_i[WIDTH-1];

    // Multiplier bits are consumed from opb_q[0]; the carry lands in the top of the shifted accumulator
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + ({1'b0, opa_q} & {(WIDTH+1){opb_q[0]}});
    assign prod    = neg_res_q ? -acc_q : acc_q;

    md_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
        .quo_i     (opa_q),
        .divisor_i (opb_q),
        .rem_o     (rem_next),
        .quo_o     (quo_next)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_a_d   = neg_a_q;
        neg_res_d = neg_res_q;
        divz_d    = divz_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    case (op_i)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            opa_d     = neg_a_in ? -a_i : a_i;
                            opb_d     = neg_b_in ? -b_i : b_i;
                            neg_a_d   = neg_a_in;
                            neg_res_d = neg_a_in ^ neg_b_in;
                            is_div_d  = op_i[1];
                            divz_d    = op_i[1] & (b_i == '0);
                            acc_d     = '0;
                            cnt_d     = '0;
                            state_d   = CALC;
                        end
                        MD_MTHI: hi_d = a_i;
                        MD_MTLO: lo_d = a_i;
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (is_div_q) begin
                    acc_d = {rem_next, acc_q[WIDTH-1:0]};
                    opa_d = quo_next;
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    opb_d = opb_q >> 1;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    // Divide by zero needs lo forced; hi already equals a via the remainder path
                    lo_d = divz_q ? '1 : (neg_res_q ? -opa_q : opa_q);
                    hi_d = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_a_q   <= 1'b0;
            neg_res_q <= 1'b0;
            divz_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_a_q   <= neg_a_d;
            neg_res_q <= neg_res_d;
            divz_q    <= divz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit
module tb_md_unit;
    import md_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int tests = 0;
    int fails = 0;

    md_unit #(
        .WIDTH(W),
        .CNT_W(6)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    always #5 clk = ~clk;

    // Drives one request from just after a falling edge; returns at the falling edge where done is seen
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int busy_cnt, output bit ok);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        busy_cnt = 0;
        ok       = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        op    = MD_MULT;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b exp 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %0b exp 0", done); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi got %h exp 0", hi); end
        tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo got %h exp 0", lo); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int bc; bit ok;
        run_op(MD_MULT, 32'hFFFF_FFFE, 32'h3, bc, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL mult_done_timeout got %0b exp 1", ok); end
        tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
        tests++; if (lo !== 32'hFFFF_FFFA) begin fails++; $display("FAIL mult_lo got %h exp fffffffa", lo); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mult_busy_at_done got %0b exp 0", busy); end
        @(negedge clk);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL mult_done_width got %0b exp 0", done); end
    endtask

    task automatic test_multu();
        int bc; bit ok;
        run_op(MD_MULTU, 32'hFFFF_FFFE, 32'h3, bc, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL multu_done_timeout got %0b exp 1", ok); end
        tests++; if (bc != 33) begin fails++; $display("FAIL multu_busy_cycles got %0d exp 33", bc); end
        tests++; if (hi !== 32'h0000_0002) begin fails++; $display("FAIL multu_hi got %h exp 00000002", hi); end
        tests++; if (lo !== 32'hFFFF_FFFA) begin fails++; $display("FAIL multu_lo got %h exp fffffffa", lo); end
        @(negedge clk);
    endtask

    task automatic test_div();
        int bc; bit ok;
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'h2, bc, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL div_done_timeout got %0b exp 1", ok); end
        tests++; if (lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_lo got %h exp fffffffd", lo); end
        tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_hi got %h exp ffffffff", hi); end
        @(negedge clk);
        run_op(MD_DIVU, 32'h7, 32'h2, bc, ok);
        tests++; if (lo !== 32'h3) begin fails++; $display("FAIL divu_lo got %h exp 00000003", lo); end
        tests++; if (hi !== 32'h1) begin fails++; $display("FAIL divu_hi got %h exp 00000001", hi); end
        tests++; if (bc != 33) begin fails++; $display("FAIL divu_busy_cycles got %0d exp 33", bc); end
        @(negedge clk);
    endtask

    task automatic test_div_corners();
        int bc; bit ok;
        run_op(MD_DIV, 32'h1234_5678, 32'h0, bc, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL divz_done_timeout got %0b exp 1", ok); end
        tests++; if (lo !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divz_lo got %h exp ffffffff", lo); end
        tests++; if (hi !== 32'h1234_5678) begin fails++; $display("FAIL divz_hi got %h exp 12345678", hi); end
        @(negedge clk);
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc, ok);
        tests++; if (lo !== 32'h8000_0000) begin fails++; $display("FAIL divmin_lo got %h exp 80000000", lo); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL divmin_hi got %h exp 00000000", hi); end
        @(negedge clk);
    endtask

    task automatic test_mtlo_mthi();
        bit seen;
        start = 1'b1; op = MD_MTLO; a = 32'hDEAD_BEEF; b = '0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        tests++; if (lo !== 32'hDEAD_BEEF) begin fails++; $display("FAIL mtlo_lo got %h exp deadbeef", lo); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mtlo_busy got %0b exp 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL mtlo_done got %0b exp 0", done); end
        @(negedge clk);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL mtlo_done_late got %0b exp 0", done); end
        // DIVU 100/7 in flight while MTHI is held on the request lines
        start = 1'b1; op = MD_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        op = MD_MTHI; a = 32'hCAFE_F00D;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mthi_busy got %0b exp 1", busy); end
        repeat (3) @(negedge clk);
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL mthi_ignored_hi got %h exp 00000000", hi); end
        start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        tests++; if (seen !== 1'b1) begin fails++; $display("FAIL mthi_div_timeout got %0b exp 1", seen); end
        tests++; if (hi !== 32'd2) begin fails++; $display("FAIL mthi_div_hi got %h exp 00000002", hi); end
        tests++; if (lo !== 32'd14) begin fails++; $display("FAIL mthi_div_lo got %h exp 0000000e", lo); end
        @(negedge clk);
    endtask

    task automatic test_bad_op();
        start = 1'b1; op = 3'b110; a = 32'h5555_AAAA; b = 32'h1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL badop_busy got %0b exp 0", busy); end
        tests++; if (hi !== 32'd2 || lo !== 32'd14) begin
            fails++; $display("FAIL badop_hilo got %h/%h exp 00000002/0000000e", hi, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int bc; bit ok;
        run_op(MD_MULTU, 32'd5, 32'd6, bc, ok);
        tests++; if (hi !== 32'h0 || lo !== 32'd30) begin
            fails++; $display("FAIL b2b_first got %h/%h exp 00000000/0000001e", hi, lo);
        end
        run_op(MD_DIVU, 32'd100, 32'd7, bc, ok);
        tests++; if (ok !== 1'b1 || bc != 33) begin
            fails++; $display("FAIL b2b_second_accept got ok=%0b busy=%0d exp ok=1 busy=33", ok, bc);
        end
        tests++; if (hi !== 32'd2 || lo !== 32'd14) begin
            fails++; $display("FAIL b2b_second got %h/%h exp 00000002/0000000e", hi, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int bc; bit ok;
        start = 1'b1; op = MD_DIVU; a = 32'h0000_1000; b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %0b exp 0", busy); end
        tests++; if (hi !== 32'h0 || lo !== 32'h0) begin
            fails++; $display("FAIL midrst_hilo got %h/%h exp 0/0", hi, lo);
        end
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (done) ok = 1'b1;
            @(negedge clk);
        end
        tests++; if (ok !== 1'b0) begin fails++; $display("FAIL midrst_no_done got %0b exp 0", ok); end
        run_op(MD_DIVU, 32'd7, 32'd2, bc, ok);
        tests++; if (ok !== 1'b1 || bc != 33) begin
            fails++; $display("FAIL midrst_restart got ok=%0b busy=%0d exp ok=1 busy=33", ok, bc);
        end
        tests++; if (hi !== 32'd1 || lo !== 32'd3) begin
            fails++; $display("FAIL midrst_result got %h/%h exp 00000001/00000003", hi, lo);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_corners();
        test_mtlo_mthi();
        test_bad_op();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
